// File: rtl/a2d_search_pkg.sv
// Shared types and elaboration-time helpers for the comparator-offset search sequencer.
package a2d_search_pkg;

    // Sequencer states; virclk is high only in the two *_HI states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRIME_HI = 3'd1,
        PRIME_LO = 3'd2,
        STEP_HI  = 3'd3,
        STEP_LO  = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Width of the shared phase counter: must hold max(PULSE_CYC, SETTLE_CYC)
    function automatic int unsigned cnt_width(input int unsigned pulse_cyc,
                                              input int unsigned settle_cyc);
        int unsigned m;
        m = (pulse_cyc > settle_cyc) ? pulse_cyc : settle_cyc;
        return $clog2(m + 1);
    endfunction

    // Start-edge to done-edge distance in clk cycles
    function automatic int unsigned TOTAL_CYC(input int unsigned n,
                                              input int unsigned p,
                                              input int unsigned s,
                                              input bit          prime);
        return (n + 32'(prime)) * (p + s);
    endfunction

endpackage

// File: rtl/a2d_search_seq_timer.sv
// Loadable down-counter that times both virclk phases; zero flag marks phase end.
module a2d_phase_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/a2d_search_seq.sv
// Drives virclk for the offset binary-search wrapper and records each comparator decision MSB-first.
module a2d_search_seq #(
    parameter int unsigned N_STEPS    = 8,
    parameter int unsigned PULSE_CYC  = 1,
    parameter int unsigned SETTLE_CYC = 4,
    parameter bit          PRIME      = 1'b1,
    parameter bit          INVERT     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         comp_out,
    output logic                         virclk,
    output logic                         busy,
    output logic                         done,
    output logic [N_STEPS-1:0]           code,
    output logic [$clog2(N_STEPS+1)-1:0] step
);
    import a2d_search_pkg::*;

    localparam int unsigned SW = $clog2(N_STEPS + 1);
    localparam int unsigned CW = cnt_width(PULSE_CYC, SETTLE_CYC);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_virclk;
    logic               r_busy;
    logic               r_done;
    logic               r_primed;
    logic [N_STEPS-1:0] r_code;
    logic [SW-1:0]      r_step;

    logic               w_virclk_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_primed_nxt;
    logic               w_restart;
    logic               w_capture;
    logic               w_bit;
    logic               w_tmr_load;
    logic               w_tmr_zero;
    logic [CW-1:0]      w_tmr_val;
    logic [N_STEPS-1:0] w_code_base;
    logic [N_STEPS-1:0] w_code_nxt;
    logic [SW-1:0]      w_step_base;
    logic [SW-1:0]      w_step_nxt;

    a2d_phase_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero_c   (w_tmr_zero)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: each HI/LO phase ends when the shared timer reaches zero
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (PRIME && !r_primed) ? PRIME_HI : STEP_HI;
                end
            end
            PRIME_HI: begin
                if (w_tmr_zero) w_state_nxt = PRIME_LO;
            end
            PRIME_LO: begin
                if (w_tmr_zero) w_state_nxt = STEP_HI;
            end
            STEP_HI: begin
                if (w_tmr_zero) w_state_nxt = STEP_LO;
            end
            STEP_LO: begin
                if (w_tmr_zero) begin
                    w_state_nxt = (r_step == SW'(N_STEPS)) ? DONE : STEP_HI;
                end
            end
            DONE: begin
                // primed is already set here, so a back-to-back start skips the prime pulse
                w_state_nxt = start ? STEP_HI : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next outputs and datapath, derived from the state being entered
    always_comb begin
        w_virclk_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_restart    = 1'b0;
        w_capture    = 1'b0;
        w_bit        = comp_out ^ INVERT;
        w_code_base  = r_code;
        w_step_base  = r_step;
        w_code_nxt   = r_code;
        w_step_nxt   = r_step;
        w_primed_nxt = r_primed;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;

        w_virclk_nxt = (w_state_nxt == PRIME_HI) || (w_state_nxt == STEP_HI);
        w_busy_nxt   = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done_nxt   = (w_state_nxt == DONE);

        // An accepted start wipes the previous result on the same edge
        w_restart = ((r_state == IDLE) || (r_state == DONE)) && w_busy_nxt;
        if (w_restart) begin
            w_code_base = '0;
            w_step_base = '0;
        end
        w_code_nxt = w_code_base;
        w_step_nxt = w_step_base;

        // Decision is latched on every STEP_HI entry, including the start edge itself
        w_capture = (w_state_nxt == STEP_HI) && (r_state != STEP_HI);
        if (w_capture) begin
            for (int i = 0; i < int'(N_STEPS); i++) begin
                if (int'(w_step_base) == int'(N_STEPS) - 1 - i) begin
                    w_code_nxt[i] = w_bit;
                end
            end
            w_step_nxt = w_step_base + SW'(1);
        end

        if (w_state_nxt == PRIME_HI) begin
            w_primed_nxt = 1'b1;
        end

        w_tmr_load = (w_state_nxt != r_state);
        w_tmr_val  = w_virclk_nxt ? CW'(PULSE_CYC - 1) : CW'(SETTLE_CYC - 1);
    end

    // Output and datapath registers; virclk is a flop so it cannot glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_virclk <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_primed <= 1'b0;
            r_code   <= '0;
            r_step   <= '0;
        end else begin
            r_virclk <= w_virclk_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_primed <= w_primed_nxt;
            r_code   <= w_code_nxt;
            r_step   <= w_step_nxt;
        end
    end

    assign virclk = r_virclk;
    assign busy   = r_busy;
    assign done   = r_done;
    assign code   = r_code;
    assign step   = r_step;

endmodule

// File: tb/tb_a2d_search_seq.sv
// Scoreboard bench for a2d_search_seq: two instances (default and N=4/P=3/S=1/INVERT) vs. a timeline model.
module tb_a2d_search_seq;

    localparam int NS  [2] = '{8, 4};
    localparam int PC  [2] = '{1, 3};
    localparam int SC  [2] = '{4, 1};
    localparam int INV [2] = '{0, 1};
    localparam int PRM [2] = '{1, 1};

    typedef struct {
        int done_cyc;
        int code;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rs [2];
    logic       st [2];
    logic       co [2];
    logic       vk [2];
    logic       bz [2];
    logic       dn [2];
    logic [7:0] code_a;
    logic [3:0] step_a;
    logic [3:0] code_b;
    logic [2:0] step_b;

    a2d_search_seq #(
        .N_STEPS(8), .PULSE_CYC(1), .SETTLE_CYC(4), .PRIME(1'b1), .INVERT(1'b0)
    ) dut_a (
        .clk(clk), .rst(rs[0]), .start(st[0]), .comp_out(co[0]),
        .virclk(vk[0]), .busy(bz[0]), .done(dn[0]), .code(code_a), .step(step_a)
    );

    a2d_search_seq #(
        .N_STEPS(4), .PULSE_CYC(3), .SETTLE_CYC(1), .PRIME(1'b1), .INVERT(1'b1)
    ) dut_b (
        .clk(clk), .rst(rs[1]), .start(st[1]), .comp_out(co[1]),
        .virclk(vk[1]), .busy(bz[1]), .done(dn[1]), .code(code_b), .step(step_b)
    );

    // Reference timeline per instance: start edge, length, prime flag, expected code
    bit   m_act    [2];
    bit   m_primed [2];
    bit   m_rand   [2];
    int   m_t0     [2];
    int   m_len    [2];
    int   m_p      [2];
    int   m_code   [2];
    int   m_next   [2];
    int   hold_code[2];
    int   hold_step[2];
    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h want %0h", nm, d, cyc, act, exp);
        end
    endfunction

    // Called at a negedge: drive start/comp_out for the next edge and update the model
    task automatic drive(input int d, input bit s);
        int   e, o, per, j;
        exp_t x;
        per   = PC[d] + SC[d];
        e     = cyc + 1;
        st[d] = s;
        if (s && !rs[d] && (!m_act[d] || e > m_t0[d] + m_len[d])) begin
            m_p[d]      = (PRM[d] != 0 && !m_primed[d]) ? 1 : 0;
            m_primed[d] = 1'b1;
            m_t0[d]     = e;
            m_len[d]    = (NS[d] + m_p[d]) * per;
            m_act[d]    = 1'b1;
            m_code[d]   = (m_rand[d] ? int'($urandom) : m_next[d]) & ((1 << NS[d]) - 1);
            x.done_cyc  = e + m_len[d];
            x.code      = m_code[d];
            if (d == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
        // Noise everywhere except at the edges where a decision is taken
        co[d] = 1'($urandom);
        if (m_act[d]) begin
            o = e - m_t0[d];
            if (o >= 0 && (o % per) == 0) begin
                j = o / per - m_p[d];
                if (j >= 0 && j < NS[d]) begin
                    co[d] = 1'(((m_code[d] >> (NS[d] - 1 - j)) & 1) ^ INV[d]);
                end
            end
        end
    endtask

    task automatic tick(input bit s0, input bit s1);
        @(negedge clk);
        drive(0, s0);
        drive(1, s1);
    endtask

    // Monitor: compare the waveform against the timeline, pop the scoreboard on done
    task automatic mon(input int d, input logic v, input logic b, input logic dd,
                       input logic [31:0] cd, input logic [31:0] sp);
        int   o, per, es, ev, eb, ed, ec, msk;
        exp_t x;
        per = PC[d] + SC[d];
        o   = m_act[d] ? cyc - m_t0[d] : -1;
        if (m_act[d] && o >= 0 && o < m_len[d]) begin
            ev  = ((o % per) < PC[d]) ? 1 : 0;
            eb  = 1;
            ed  = 0;
            es  = (o < m_p[d] * per) ? 0 : o / per - m_p[d] + 1;
            msk = ((1 << es) - 1) << (NS[d] - es);
            ec  = m_code[d] & msk;
        end else if (m_act[d] && o == m_len[d]) begin
            ev = 0; eb = 0; ed = 1;
            es = NS[d];
            ec = m_code[d];
            hold_code[d] = m_code[d];
            hold_step[d] = NS[d];
        end else begin
            ev = 0; eb = 0; ed = 0;
            es = hold_step[d];
            ec = hold_code[d];
        end
        chk("virclk", d, 32'(v), ev);
        chk("busy",   d, 32'(b), eb);
        chk("done",   d, 32'(dd), ed);
        chk("step",   d, sp, es);
        chk("code",   d, cd, ec);
        if (dd === 1'b1) begin
            total++;
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                bad++;
                $display("FAIL sb_done dut%0d cyc=%0d: got done=1 want no done (nothing pending)", d, cyc);
            end else begin
                x = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("sb_code",    d, cd, x.code);
                chk("sb_latency", d, cyc, x.done_cyc);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, vk[0], bz[0], dn[0], 32'(code_a), 32'(step_a));
            mon(1, vk[1], bz[1], dn[1], 32'(code_b), 32'(step_b));
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rs[d] = 1'b1; st[d] = 1'b0; co[d] = 1'b0;
            m_act[d] = 1'b0; m_primed[d] = 1'b0; m_rand[d] = 1'b1;
            m_next[d] = 0; hold_code[d] = 0; hold_step[d] = 0;
            m_t0[d] = 0; m_len[d] = 0; m_p[d] = 0; m_code[d] = 0;
        end
        repeat (3) @(negedge clk);
        rs[0] = 1'b0;
        rs[1] = 1'b0;
        repeat (2) tick(1'b0, 1'b0);

        // First search: prime pulse, all-ones code; dut_b inverted zeros, extra starts while busy
        m_rand[0] = 1'b0; m_next[0] = 8'hFF;
        m_rand[1] = 1'b0; m_next[1] = 4'hF;
        for (int i = 0; i < 52; i++) tick(i == 0 || i == 20, i == 0 || i == 6 || i == 11);
        repeat (4) tick(1'b0, 1'b0);

        // Second search: no prime, alternating decisions
        m_next[0] = 8'hAA;
        m_rand[1] = 1'b1;
        for (int i = 0; i < 48; i++) tick(i == 0, i == 0);
        repeat (4) tick(1'b0, 1'b0);

        // Start held through DONE: back-to-back searches with no IDLE cycle
        m_rand[0] = 1'b1;
        for (int i = 0; i < 130; i++) tick(1'b1, 1'b1);
        repeat (50) tick(1'b0, 1'b0);

        // Random start traffic
        for (int i = 0; i < 600; i++) tick(($urandom % 8) == 0, ($urandom % 6) == 0);
        repeat (60) tick(1'b0, 1'b0);

        // Async reset mid-search at step 3 while virclk is high
        m_rand[0] = 1'b0; m_next[0] = 8'hE5;
        tick(1'b1, 1'b0);
        repeat (11) tick(1'b0, 1'b0);
        chk("pre_rst_virclk", 0, 32'(vk[0]), 1);
        chk("pre_rst_step",   0, 32'(step_a), 3);
        rs[0] = 1'b1;
        #1;
        chk("rst_virclk", 0, 32'(vk[0]), 0);
        chk("rst_busy",   0, 32'(bz[0]), 0);
        chk("rst_code",   0, 32'(code_a), 0);
        chk("rst_step",   0, 32'(step_a), 0);
        m_act[0] = 1'b0; m_primed[0] = 1'b0;
        hold_code[0] = 0; hold_step[0] = 0;
        q0.delete();
        repeat (2) tick(1'b0, 1'b0);
        rs[0] = 1'b0;
        m_rand[0] = 1'b1;
        tick(1'b1, 1'b0);
        repeat (55) tick(1'b0, 1'b0);

        chk("sb_drain", 0, q0.size(), 0);
        chk("sb_drain", 1, q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
